// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the dmem_mmio data-memory / MMIO subsystem.
// Optional timer prescaler is enabled by defining DMEM_MMIO_TIMER_PRESCALE_EN.
package dmem_mmio_pkg;

    localparam logic [15:0] MMIO_HI_DEF  = 16'hFFFF;

    localparam logic [7:0]  GPIO_OUT_OFF = 8'h00;
    localparam logic [7:0]  GPIO_IN_OFF  = 8'h04;
    localparam logic [7:0]  TCNT_OFF     = 8'h08;
    localparam logic [7:0]  TCMP_OFF     = 8'h0C;
    localparam logic [7:0]  TCTRL_OFF    = 8'h10;
    localparam logic [7:0]  TSTAT_OFF    = 8'h14;
    localparam logic [7:0]  TPSC_OFF     = 8'h1C;

    localparam int unsigned TCTRL_EN     = 0;
    localparam int unsigned TCTRL_AR     = 1;
    localparam int unsigned TCTRL_IE     = 2;
    localparam int unsigned TSTAT_MATCH  = 0;

    localparam logic [31:0] TCMP_RST     = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_RAM  = 2'd1,
        REGION_MMIO = 2'd2
    } region_t;

endpackage

// File: rtl/mmio_timer.sv
// Compare timer with auto-reload, interrupt enable and W1C match flag.
// Prescaler register TPSC exists only with DMEM_MMIO_TIMER_PRESCALE_EN defined.
module mmio_timer
    import dmem_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [7:0]  off,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [31:0] tcnt;
    logic [31:0] tcmp;
    logic [2:0]  tctrl;
    logic        match;
    logic        tick;
    logic        hit;
    logic        wr_tcnt;
    logic        wr_tcmp;
    logic        wr_tctrl;
    logic        wr_tstat;

    assign wr_tcnt  = we && (off == TCNT_OFF);
    assign wr_tcmp  = we && (off == TCMP_OFF);
    assign wr_tctrl = we && (off == TCTRL_OFF);
    assign wr_tstat = we && (off == TSTAT_OFF);

`ifdef DMEM_MMIO_TIMER_PRESCALE_EN
    logic [15:0] tpsc;
    logic [15:0] psc_cnt;
    logic        wr_tpsc;

    assign wr_tpsc = we && (off == TPSC_OFF);
    assign tick    = (psc_cnt == tpsc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tpsc    <= '0;
            psc_cnt <= '0;
        end else if (wr_tpsc) begin
            tpsc    <= wdata[15:0];
            psc_cnt <= '0;
        end else if (tctrl[TCTRL_EN]) begin
            psc_cnt <= tick ? '0 : psc_cnt + 16'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Compare always sees the pre-write TCNT, so a software write cannot mask a match.
    assign hit = tctrl[TCTRL_EN] && tick && (tcnt == tcmp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt  <= '0;
            tcmp  <= TCMP_RST;
            tctrl <= '0;
            match <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (wr_tcnt)
                tcnt <= wdata;
            else if (tctrl[TCTRL_EN] && tick)
                tcnt <= (hit && tctrl[TCTRL_AR]) ? '0 : tcnt + 32'd1;

            if (wr_tcmp)
                tcmp <= wdata;
            if (wr_tctrl)
                tctrl <= wdata[2:0];

            if (hit)
                match <= 1'b1;
            else if (wr_tstat && wdata[TSTAT_MATCH])
                match <= 1'b0;

            irq <= match && tctrl[TCTRL_IE];
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            TCNT_OFF:  rdata = tcnt;
            TCMP_OFF:  rdata = tcmp;
            TCTRL_OFF: rdata = {29'd0, tctrl};
            TSTAT_OFF: rdata = {31'd0, match};
`ifdef DMEM_MMIO_TIMER_PRESCALE_EN
            TPSC_OFF:  rdata = {16'd0, tpsc};
`endif
            default:   rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO window (GPIO, synchronised GPIO input, compare timer).
// Timer prescaler is optional via DMEM_MMIO_TIMER_PRESCALE_EN.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter logic [15:0] MMIO_HI    = MMIO_HI_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_dm,
    input  logic [31:0] alu_out,
    input  logic [31:0] wd_dm,
    output logic [31:0] rd_dm,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic        timer_irq,
    output logic        addr_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           ram [DEPTH];
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [7:0]            mmio_off;
    logic                  aligned;
    region_t               region;
    logic                  ram_we;
    logic                  mmio_we;
    logic [31:0]           gpio_s1;
    logic [31:0]           gpio_s2;
    logic [31:0]           timer_rdata;

    assign ram_idx  = alu_out[DEPTH_LOG2+1:2];
    assign mmio_off = alu_out[7:0];
    assign aligned  = (alu_out[1:0] == 2'b00);

    always_comb begin
        region = REGION_NONE;
        if (alu_out[31:DEPTH_LOG2+2] == '0)
            region = REGION_RAM;
        else if ((alu_out[31:16] == MMIO_HI) && (alu_out[15:8] == 8'h00))
            region = REGION_MMIO;
    end

    assign addr_err = !aligned || (region == REGION_NONE);
    assign ram_we   = we_dm && !addr_err && (region == REGION_RAM);
    assign mmio_we  = we_dm && !addr_err && (region == REGION_MMIO);

    // RAM deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_idx] <= wd_dm;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_out <= '0;
            gpio_s1  <= '0;
            gpio_s2  <= '0;
        end else begin
            if (mmio_we && (mmio_off == GPIO_OUT_OFF))
                gpio_out <= wd_dm;
            gpio_s1 <= gpio_in;
            gpio_s2 <= gpio_s1;
        end
    end

    mmio_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .we    (mmio_we),
        .off   (mmio_off),
        .wdata (wd_dm),
        .rdata (timer_rdata),
        .irq   (timer_irq)
    );

    always_comb begin
        rd_dm = '0;
        if (!addr_err) begin
            if (region == REGION_RAM)
                rd_dm = ram[ram_idx];
            else if (mmio_off == GPIO_OUT_OFF)
                rd_dm = gpio_out;
            else if (mmio_off == GPIO_IN_OFF)
                rd_dm = gpio_s2;
            else
                rd_dm = timer_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus randomized traffic
// against a behavioural model. Define DMEM_MMIO_TIMER_PRESCALE_EN to cover TPSC.
module tb_dmem_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_dm;
    logic [31:0] alu_out;
    logic [31:0] wd_dm;
    logic [31:0] rd_dm;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        timer_irq;
    logic        addr_err;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    dmem_mmio #(.DEPTH_LOG2(6), .MMIO_HI(16'hFFFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .we_dm     (we_dm),
        .alu_out   (alu_out),
        .wd_dm     (wd_dm),
        .rd_dm     (rd_dm),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq),
        .addr_err  (addr_err)
    );

    // Behavioural model state
    logic [31:0] m_ram [64];
    logic [31:0] m_gpio_out;
    logic [31:0] m_s1, m_s2;
    logic [31:0] m_tcnt, m_tcmp;
    logic        m_en, m_ar, m_ie, m_match, m_irq;
    logic [15:0] m_tpsc, m_pc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_gpio_out = 0; m_s1 = 0; m_s2 = 0;
        m_tcnt = 0; m_tcmp = 32'hFFFF_FFFF;
        m_en = 0; m_ar = 0; m_ie = 0; m_match = 0; m_irq = 0;
        m_tpsc = 0; m_pc = 0;
    endtask

    // kind: 0 unmapped/unaligned, 1 RAM, 2 MMIO
    function automatic int addr_kind(input logic [31:0] a);
        if (a % 4 != 0) return 0;
        if (a < 256) return 1;
        if ((a >> 16) == 32'hFFFF && ((a >> 8) & 32'hFF) == 0) return 2;
        return 0;
    endfunction

    function automatic void model_read(input logic [31:0] a, output logic [31:0] rd, output logic err);
        int k;
        k = addr_kind(a);
        rd = 0;
        err = (k == 0);
        if (k == 1) rd = m_ram[a / 4];
        if (k == 2) begin
            case (a & 32'hFF)
                32'h00: rd = m_gpio_out;
                32'h04: rd = m_s2;
                32'h08: rd = m_tcnt;
                32'h0C: rd = m_tcmp;
                32'h10: rd = {29'd0, m_ie, m_ar, m_en};
                32'h14: rd = {31'd0, m_match};
`ifdef DMEM_MMIO_TIMER_PRESCALE_EN
                32'h1C: rd = {16'd0, m_tpsc};
`endif
                default: rd = 0;
            endcase
        end
    endfunction

    // One clock edge of the specified behaviour; all decisions use pre-edge state.
    task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] gin);
        int k;
        logic [31:0] off;
        logic tick, match_now, counting, sw_tcnt;
        k = addr_kind(a);
        off = a & 32'hFF;
`ifdef DMEM_MMIO_TIMER_PRESCALE_EN
        tick = (m_pc == m_tpsc);
`else
        tick = 1'b1;
`endif
        counting  = m_en && tick;
        match_now = counting && (m_tcnt == m_tcmp);
        sw_tcnt   = we && k == 2 && off == 32'h08;
        m_irq = m_match && m_ie;

        if (sw_tcnt) m_tcnt = wd;
        else if (match_now && m_ar) m_tcnt = 0;
        else if (counting) m_tcnt = m_tcnt + 1;

        if (match_now) m_match = 1;
        else if (we && k == 2 && off == 32'h14 && wd[0]) m_match = 0;

`ifdef DMEM_MMIO_TIMER_PRESCALE_EN
        if (we && k == 2 && off == 32'h1C) begin
            m_tpsc = wd[15:0];
            m_pc = 0;
        end else if (m_en) begin
            m_pc = tick ? 16'd0 : m_pc + 16'd1;
        end
`endif
        if (we && k == 2 && off == 32'h0C) m_tcmp = wd;
        if (we && k == 2 && off == 32'h10) begin
            m_en = wd[0]; m_ar = wd[1]; m_ie = wd[2];
        end
        if (we && k == 2 && off == 32'h00) m_gpio_out = wd;
        if (we && k == 1) m_ram[a / 4] = wd;
        m_s2 = m_s1;
        m_s1 = gin;
    endtask

    // Drive one access, check combinational outputs mid-cycle, then registered ones after the edge.
    task automatic do_cycle(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] gin, output logic [31:0] rd_seen);
        logic [31:0] exp_rd;
        logic exp_err;
        we_dm = we; alu_out = a; wd_dm = wd; gpio_in = gin;
        @(negedge clk);
        model_read(a, exp_rd, exp_err);
        check_eq("rd_dm", rd_dm, exp_rd);
        check_eq("addr_err", {31'd0, addr_err}, {31'd0, exp_err});
        rd_seen = rd_dm;
        @(posedge clk);
        model_step(we, a, wd, gin);
        #1;
        check_eq("gpio_out", gpio_out, m_gpio_out);
        check_eq("timer_irq", {31'd0, timer_irq}, {31'd0, m_irq});
        we_dm = 1'b0;
    endtask

    logic [31:0] gin_cur = 0;

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        do_cycle(1'b1, a, d, gin_cur, r);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        do_cycle(1'b0, a, 32'h0, gin_cur, r);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1: return $urandom_range(0, 63) * 4;
            2:    return 32'hFFFF_0000 | ($urandom_range(0, 7) * 4);
            3:    return 32'hFFFF_0000 | $urandom_range(0, 255);
            4:    return 32'hFFFF_0000 | ($urandom_range(1, 255) << 8) | ($urandom_range(0, 7) * 4);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        logic [31:0] a, d;
        logic [31:0] seq [9];

        rst = 1'b1; we_dm = 0; alu_out = 32'hFFFF_000C; wd_dm = 0; gpio_in = 0;
        model_reset();
        #3;
        check_eq("rst_tcmp", rd_dm, 32'hFFFF_FFFF);
        check_eq("rst_gpio_out", gpio_out, 32'h0);
        check_eq("rst_irq", {31'd0, timer_irq}, 32'h0);
        @(posedge clk); #1; rst = 1'b0;

        // Fill RAM so every later read has a defined expectation
        for (int i = 0; i < 64; i++) wr(i * 4, $urandom);

        // RAM, out-of-range, unaligned
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, r);          check_eq("ram_rd_10", r, 32'hDEAD_BEEF);
        rd(32'h100, r);         check_eq("rd_oob", r, 32'h0);
        check_eq("err_oob", {31'd0, addr_err}, 32'h1);
        wr(32'h100, 32'hCAFE_F00D);
        rd(32'h0, r);           check_eq("ram_rd_0_after_oob", r, m_ram[0]);
        alu_out = 32'h12; #1;   check_eq("err_unaligned", {31'd0, addr_err}, 32'h1);
        wr(32'h12, 32'h1234_5678);
        rd(32'h10, r);          check_eq("ram_rd_10_after_unal", r, 32'hDEAD_BEEF);

        // GPIO out and synchronised in
        wr(32'hFFFF_0000, 32'hA5);
        check_eq("gpio_out_a5", gpio_out, 32'hA5);
        gin_cur = 32'h3C;
        rd(32'hFFFF_0004, r);   check_eq("gpio_in_c0", r, 32'h0);
        rd(32'hFFFF_0004, r);   check_eq("gpio_in_c1", r, 32'h0);
        rd(32'hFFFF_0004, r);   check_eq("gpio_in_c2", r, 32'h3C);

        // One-shot timer with interrupt
        wr(32'hFFFF_000C, 5);
        wr(32'hFFFF_0010, 32'h5);
        for (int i = 0; i < 7; i++) begin
            rd(32'hFFFF_0008, r);
            check_eq("oneshot_tcnt", r, i);
        end
        check_eq("oneshot_irq", {31'd0, timer_irq}, 32'h1);
        rd(32'hFFFF_0014, r);   check_eq("oneshot_match", r, 32'h1);
        wr(32'hFFFF_0014, 32'h1);
        rd(32'hFFFF_0014, r);   check_eq("w1c_match", r, 32'h0);
        check_eq("w1c_irq", {31'd0, timer_irq}, 32'h0);

        // Auto-reload and TCNT write colliding with a match
        wr(32'hFFFF_0010, 32'h0);
        wr(32'hFFFF_0008, 32'h0);
        wr(32'hFFFF_000C, 3);
        wr(32'hFFFF_0010, 32'h3);
        for (int i = 0; i < 6; i++) rd(32'hFFFF_0008, seq[i]);
        check_eq("ar_seq3", seq[3], 3);
        check_eq("ar_seq4", seq[4], 0);
        check_eq("ar_seq5", seq[5], 1);
        wr(32'hFFFF_0014, 32'h1);      // TCNT 2 -> 3, MATCH cleared
        wr(32'hFFFF_0008, 32'h100);    // collides with match at TCNT=3
        rd(32'hFFFF_0008, r);   check_eq("collide_tcnt", r, 32'h100);
        rd(32'hFFFF_0014, r);   check_eq("collide_match", r, 32'h1);

        // Asynchronous reset mid-count
        alu_out = 32'hFFFF_0008; #2;
        rst = 1'b1; #1;
        check_eq("arst_tcnt", rd_dm, 32'h0);
        alu_out = 32'hFFFF_0010; #1;
        check_eq("arst_tctrl", rd_dm, 32'h0);
        alu_out = 32'h10; #1;
        check_eq("arst_ram_kept", rd_dm, 32'hDEAD_BEEF);
        check_eq("arst_gpio_out", gpio_out, 32'h0);
        model_reset();
        gin_cur = 0;
        gpio_in = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

`ifdef DMEM_MMIO_TIMER_PRESCALE_EN
        wr(32'hFFFF_001C, 2);
        wr(32'hFFFF_0010, 32'h1);
        for (int i = 0; i < 9; i++) rd(32'hFFFF_0008, seq[i]);
        for (int i = 0; i < 9; i++) check_eq("psc_tcnt", seq[i], i / 3);
        wr(32'hFFFF_0010, 32'h0);
        wr(32'hFFFF_001C, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            a = rand_addr();
            d = $urandom;
            if (addr_kind(a) == 2 && ((a & 32'hFF) == 32'h08 || (a & 32'hFF) == 32'h0C))
                d = $urandom_range(0, 40);
            if (addr_kind(a) == 2 && (a & 32'hFF) == 32'h1C)
                d = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) gin_cur = $urandom;
            do_cycle(1'($urandom_range(0, 1)), a, d, gin_cur, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
